// File: rtl/axi_lite_stopwatch_multi.sv
// Multi-channel stopwatch behind an AXI4-Lite slave. Each channel has a prescaled
// up-counter, a lap capture register with a saturating lap count, and a sticky overflow flag.
module axi_lite_stopwatch_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 32,
    parameter int TICK_DIV = 100,
    parameter int ADDR_W   = 7
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [2:0]        AWPROT,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [2:0]        ARPROT,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              irq
);
    localparam int               PRE_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST    = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;

    logic [NUM_CH-1:0] r_run;
    logic [NUM_CH-1:0] r_ovf;
    logic [CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [CNT_W-1:0]  r_lap  [NUM_CH];
    logic [15:0]       r_lapn [NUM_CH];
    logic [PRE_W-1:0]  r_pre  [NUM_CH];

    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [31:0]       w_wch;
    logic [31:0]       w_rch;
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_wsel;
    logic [31:0]       w_rdata_mux;
    logic              w_unused;

    // Channel index is widened so out-of-range channels compare cleanly against NUM_CH.
    assign w_wch    = 32'(AWADDR[ADDR_W-1:4]);
    assign w_rch    = 32'(ARADDR[ADDR_W-1:4]);
    assign w_wr_acc = AWVALID & WVALID & ~r_bvalid & ~ARESET;
    assign w_rd_acc = ARVALID & ~r_rvalid & ~ARESET;

    assign AWREADY = w_wr_acc;
    assign WREADY  = w_wr_acc;
    assign ARREADY = w_rd_acc;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign RVALID  = r_rvalid;
    assign RRESP   = r_rresp;
    assign RDATA   = r_rdata;
    assign irq     = |r_ovf;

    assign w_unused = ^{AWPROT, ARPROT, WSTRB[3:1], WDATA[31:3], AWADDR[1:0], ARADDR[1:0]};

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_tick      = '0;
        w_wsel      = '0;
        w_rdata_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_tick[c] = r_run[c] && (r_pre[c] == PRE_LAST);
            w_wsel[c] = w_wr_acc && (w_wch == 32'(c)) && (AWADDR[3:2] == 2'd0) && WSTRB[0];
            if (w_rch == 32'(c)) begin
                case (ARADDR[3:2])
                    2'd0:    w_rdata_mux = {23'd0, r_ovf[c], 7'd0, r_run[c]};
                    2'd1:    w_rdata_mux = 32'(r_cnt[c]);
                    2'd2:    w_rdata_mux = 32'(r_lap[c]);
                    default: w_rdata_mux = 32'(r_lapn[c]);
                endcase
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (w_wch < NUM_CH) ? RESP_OKAY : RESP_SLVERR;
            end else if (BREADY) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd_acc) begin
                r_rvalid <= 1'b1;
                r_rresp  <= (w_rch < NUM_CH) ? RESP_OKAY : RESP_SLVERR;
                r_rdata  <= w_rdata_mux;
            end else if (RREADY) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // NOTE: the per-channel arrays are small register banks, not RAM, so they are reset like any other state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_run <= '0;
            r_ovf <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c]  <= '0;
                r_lap[c]  <= '0;
                r_lapn[c] <= '0;
                r_pre[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_tick[c]) begin
                    r_pre[c] <= '0;
                    r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                    if (r_cnt[c] == CNT_MAX) r_ovf[c] <= 1'b1;
                end else if (r_run[c]) begin
                    r_pre[c] <= r_pre[c] + PRE_W'(1);
                end
                // Later assignments override the tick update, so CLEAR wins over a coincident tick.
                if (w_wsel[c]) begin
                    r_run[c] <= WDATA[0];
                    if (WDATA[1]) begin
                        r_cnt[c]  <= '0;
                        r_lap[c]  <= '0;
                        r_lapn[c] <= '0;
                        r_pre[c]  <= '0;
                        r_ovf[c]  <= 1'b0;
                    end else if (WDATA[2]) begin
                        r_lap[c] <= r_cnt[c];
                        if (r_lapn[c] != 16'hFFFF) r_lapn[c] <= r_lapn[c] + 16'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_stopwatch_multi.sv
// Randomized AXI-Lite traffic against the stopwatch, compared every cycle with an
// elapsed-time model, plus directed scenarios with hand-computed expectations.
module tb_axi_lite_stopwatch_multi;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int TICK_DIV = 4;
    localparam int ADDR_W   = 7;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [ADDR_W-1:0] AWADDR = '0;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [2:0]        AWPROT = 3'd0;
    logic [31:0]       WDATA = '0;
    logic [3:0]        WSTRB = '0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [ADDR_W-1:0] ARADDR = '0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [2:0]        ARPROT = 3'd0;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic              irq;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    axi_lite_stopwatch_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARPROT(ARPROT),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] act, input int lo, input int hi);
        n_chk++;
        if (act < 32'(lo) || act > 32'(hi)) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Model: a channel's state is its running-cycle total since the last clear/reset.
    longint      m_rc   [NUM_CH];
    bit          m_run  [NUM_CH];
    logic [31:0] m_lap  [NUM_CH];
    int          m_lapn [NUM_CH];
    bit          m_bvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    bit          m_rvalid = 1'b0;
    logic [1:0]  m_rresp = 2'b00;
    logic [31:0] m_rdata = '0;
    bit          mw_acc, mr_acc;
    logic [31:0] m_lapv;

    function automatic logic [31:0] m_count(input int c);
        return 32'((m_rc[c] / TICK_DIV) % (longint'(1) << CNT_W));
    endfunction

    function automatic bit m_ovf(input int c);
        return (m_rc[c] / TICK_DIV) >= (longint'(1) << CNT_W);
    endfunction

    function automatic bit m_irq();
        bit any = 1'b0;
        for (int c = 0; c < NUM_CH; c++) any |= m_ovf(c);
        return any;
    endfunction

    function automatic logic [31:0] m_reg(input int c, input logic [1:0] r);
        case (r)
            2'd0:    return {23'd0, m_ovf(c), 7'd0, m_run[c]};
            2'd1:    return m_count(c);
            2'd2:    return m_lap[c];
            default: return 32'(m_lapn[c]);
        endcase
    endfunction

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            m_rc[c] = 0; m_run[c] = 1'b0; m_lap[c] = '0; m_lapn[c] = 0;
        end
    end

    always @(posedge ACLK) begin
        if (ARESET) begin
            m_bvalid = 1'b0; m_bresp = 2'b00;
            m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_rc[c] = 0; m_run[c] = 1'b0; m_lap[c] = '0; m_lapn[c] = 0;
            end
        end else begin
            mw_acc = AWVALID && WVALID && !m_bvalid;
            mr_acc = ARVALID && !m_rvalid;
            if (m_bvalid && BREADY) m_bvalid = 1'b0;
            if (m_rvalid && RREADY) m_rvalid = 1'b0;
            if (mr_acc) begin
                m_rvalid = 1'b1;
                if (int'(ARADDR[6:4]) < NUM_CH) begin
                    m_rresp = 2'b00;
                    m_rdata = m_reg(int'(ARADDR[6:4]), ARADDR[3:2]);
                end else begin
                    m_rresp = 2'b10;
                    m_rdata = '0;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                m_lapv = m_count(c);
                if (m_run[c]) m_rc[c]++;
                if (mw_acc && int'(AWADDR[6:4]) == c && AWADDR[3:2] == 2'd0 && WSTRB[0]) begin
                    m_run[c] = WDATA[0];
                    if (WDATA[1]) begin
                        m_rc[c] = 0; m_lap[c] = '0; m_lapn[c] = 0;
                    end else if (WDATA[2]) begin
                        m_lap[c] = m_lapv;
                        if (m_lapn[c] < 65535) m_lapn[c]++;
                    end
                end
            end
            if (mw_acc) begin
                m_bvalid = 1'b1;
                m_bresp  = (int'(AWADDR[6:4]) < NUM_CH) ? 2'b00 : 2'b10;
            end
        end
    end

    always @(negedge ACLK) begin
        if (cmp_en) begin
            check("awready", 32'(AWREADY), 32'(AWVALID && WVALID && !m_bvalid && !ARESET));
            check("wready", 32'(WREADY), 32'(AWVALID && WVALID && !m_bvalid && !ARESET));
            check("arready", 32'(ARREADY), 32'(ARVALID && !m_rvalid && !ARESET));
            check("bvalid", 32'(BVALID), 32'(m_bvalid));
            if (m_bvalid) check("bresp", 32'(BRESP), 32'(m_bresp));
            check("rvalid", 32'(RVALID), 32'(m_rvalid));
            if (m_rvalid) begin
                check("rdata", RDATA, m_rdata);
                check("rresp", 32'(RRESP), 32'(m_rresp));
            end
            check("irq", 32'(irq), 32'(m_irq()));
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int bdelay, output logic [1:0] resp);
        int n;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        #1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 50) begin @(posedge ACLK); #2; n++; end
        if (n == 50) check("write_accept_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        repeat (bdelay) step();
        BREADY = 1'b1;
        #1;
        n = 0;
        while (!BVALID && n < 50) begin @(posedge ACLK); #2; n++; end
        if (n == 50) check("bvalid_timeout", 32'd0, 32'd1);
        resp = BRESP;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] a, input int rdelay,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        ARADDR = a; ARVALID = 1'b1;
        #1;
        n = 0;
        while (!ARREADY && n < 50) begin @(posedge ACLK); #2; n++; end
        if (n == 50) check("read_accept_timeout", 32'd0, 32'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        repeat (rdelay) step();
        RREADY = 1'b1;
        #1;
        n = 0;
        while (!RVALID && n < 50) begin @(posedge ACLK); #2; n++; end
        if (n == 50) check("rvalid_timeout", 32'd0, 32'd1);
        data = RDATA; resp = RRESP;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  rsp;
        logic [2:0]  ch;
        logic [1:0]  rg;
        logic [3:0]  st;
        int n;

        // Reset state
        ARESET = 1'b1;
        step(); step();
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_rdata", RDATA, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_resp", 32'({BRESP, RRESP}), 32'd0);
        cmp_en = 1'b1;
        ARESET = 1'b0;
        step();

        // ch0 runs for ~40 cycles at 4 cycles/tick
        axi_write(7'h00, 32'h1, 4'hF, 0, rsp);
        check("run_bresp", 32'(rsp), 32'd0);
        repeat (39) step();
        axi_read(7'h04, 0, d, rsp);
        check_range("ch0_count_40cyc", d, 9, 11);
        check("ch0_count_rresp", 32'(rsp), 32'd0);

        // ch1 lap at COUNT=7, then a second lap
        axi_write(7'h10, 32'h1, 4'hF, 0, rsp);
        repeat (28) step();
        axi_write(7'h10, 32'h5, 4'hF, 0, rsp);
        axi_read(7'h18, 0, d, rsp);
        check("ch1_lap", d, 32'd7);
        axi_read(7'h1C, 0, d, rsp);
        check("ch1_lapn1", d, 32'd1);
        axi_read(7'h10, 0, d, rsp);
        check("ch1_ctrl_run", d, 32'h1);
        repeat (10) step();
        axi_write(7'h10, 32'h5, 4'hF, 0, rsp);
        axi_read(7'h1C, 0, d, rsp);
        check("ch1_lapn2", d, 32'd2);

        // Stop and clear ch0/ch1, then overflow ch2 (256 ticks = 1024 cycles)
        axi_write(7'h00, 32'h2, 4'hF, 0, rsp);
        axi_write(7'h10, 32'h2, 4'hF, 0, rsp);
        axi_write(7'h20, 32'h1, 4'hF, 0, rsp);
        repeat (1030) step();
        axi_read(7'h24, 0, d, rsp);
        check_range("ch2_count_wrapped", d, 0, 2);
        axi_read(7'h20, 0, d, rsp);
        check("ch2_ctrl_ovf", d, 32'h101);
        check("irq_set", 32'(irq), 32'd1);
        axi_write(7'h20, 32'h3, 4'hF, 0, rsp);
        check("irq_cleared", 32'(irq), 32'd0);
        axi_read(7'h24, 0, d, rsp);
        check("ch2_count_cleared", d, 32'd0);
        axi_read(7'h20, 0, d, rsp);
        check("ch2_ctrl_after_clear", d, 32'h1);

        // Out-of-range channel, slow BREADY
        axi_write(7'h40, 32'h1, 4'hF, 5, rsp);
        check("bad_ch_bresp", 32'(rsp), 32'd2);
        axi_read(7'h40, 0, d, rsp);
        check("bad_ch_rresp", 32'(rsp), 32'd2);
        check("bad_ch_rdata", d, 32'd0);
        axi_read(7'h00, 0, d, rsp);
        check("ch0_untouched", d, 32'd0);
        axi_write(7'h04, 32'hFF, 4'hF, 0, rsp);
        check("ro_write_okay", 32'(rsp), 32'd0);

        // Reset with a read response pending
        axi_write(7'h30, 32'h1, 4'hF, 0, rsp);
        axi_write(7'h10, 32'h1, 4'hF, 0, rsp);
        repeat (20) step();
        ARADDR = 7'h34; ARVALID = 1'b1;
        #1;
        n = 0;
        while (!ARREADY && n < 50) begin @(posedge ACLK); #2; n++; end
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        step(); step();
        check("rvalid_pending", 32'(RVALID), 32'd1);
        ARESET = 1'b1;
        step();
        check("rst_aborts_rvalid", 32'(RVALID), 32'd0);
        check("rst_rdata_zero", RDATA, 32'd0);
        ARESET = 1'b0;
        axi_read(7'h34, 0, d, rsp);
        check("post_rst_ch3_count", d, 32'd0);
        axi_read(7'h10, 0, d, rsp);
        check("post_rst_ch1_ctrl", d, 32'd0);
        axi_write(7'h00, 32'h1, 4'hF, 0, rsp);
        check("post_rst_bresp", 32'(rsp), 32'd0);
        axi_read(7'h00, 0, d, rsp);
        check("post_rst_ch0_run", d, 32'h1);

        // Random traffic, checked each cycle by the model
        for (int i = 0; i < 300; i++) begin
            ch = 3'($urandom_range(0, 5));
            rg = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) begin
                ARESET = 1'b1;
                step();
                ARESET = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                if ($urandom_range(0, 4) != 0) d[1] = 1'b0;
                if ($urandom_range(0, 2) != 0) d[0] = 1'b1;
                st = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) != 0) st[0] = 1'b1;
                if ($urandom_range(0, 2) != 0) rg = 2'd0;
                axi_write({ch, rg, 2'b00}, d, st, int'($urandom_range(0, 3)), rsp);
            end else begin
                axi_read({ch, rg, 2'b00}, int'($urandom_range(0, 3)), d, rsp);
            end
            repeat ($urandom_range(0, 4)) step();
        end

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
